// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids, default watchdog.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin picker, purely combinational; grant[0]=IFU, grant[1]=LSU.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_t     last_owner,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      grant = (last_owner == OWN_LSU) ? 2'b01 : 2'b10;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end
  end
endmodule

// File: rtl/mem_arb.sv
// IFU/LSU round-robin arbiter onto one memory port: accept->mem_req 1 cycle, mem_rsp->owner rsp 1 cycle.
// One transaction in flight; requesters see ready only in IDLE, memory stalls hold the latched request.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [WIDTH-1:0]   ifu_addr,
  output logic               ifu_rsp_valid,
  output logic [WIDTH-1:0]   ifu_rsp_data,
  output logic               ifu_rsp_err,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [WIDTH-1:0]   lsu_addr,
  input  logic               lsu_we,
  input  logic [WIDTH-1:0]   lsu_wdata,
  input  logic [WIDTH/8-1:0] lsu_wmask,
  output logic               lsu_rsp_valid,
  output logic [WIDTH-1:0]   lsu_rsp_data,
  output logic               lsu_rsp_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_we,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_wmask,
  input  logic               mem_rsp_valid,
  input  logic [WIDTH-1:0]   mem_rsp_data
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef struct packed {
    logic [WIDTH-1:0]   addr;
    logic               we;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] wmask;
  } req_t;

  state_t        state;
  owner_t        owner;
  owner_t        last_owner;
  owner_t        pick;
  logic [1:0]    grant;
  logic [CW-1:0] cnt;
  req_t          lat;
  req_t          sel_req;
  logic          done;
  logic [WIDTH-1:0] rsp_d;

  rr_arb2 u_arb (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner),
    .grant      (grant)
  );

  assign ifu_req_ready = (state == IDLE) && grant[0];
  assign lsu_req_ready = (state == IDLE) && grant[1];
  assign pick          = grant[1] ? OWN_LSU : OWN_IFU;

  // IFU is read-only, so its write fields are forced to zero in the latch.
  always_comb begin
    sel_req = '0;
    if (grant[1]) begin
      sel_req.addr  = lsu_addr;
      sel_req.we    = lsu_we;
      sel_req.wdata = lsu_wdata;
      sel_req.wmask = lsu_wmask;
    end else begin
      sel_req.addr  = ifu_addr;
    end
  end

  assign mem_addr  = lat.addr;
  assign mem_we    = lat.we;
  assign mem_wdata = lat.wdata;
  assign mem_wmask = lat.wmask;

  // A real response wins over a watchdog expiry landing in the same cycle.
  assign done  = mem_rsp_valid || (cnt == TMAX);
  assign rsp_d = (mem_rsp_valid && !lat.we) ? mem_rsp_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= OWN_IFU;
      last_owner    <= OWN_LSU;
      cnt           <= '0;
      lat           <= '0;
      mem_req_valid <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner         <= pick;
            last_owner    <= pick;
            lat           <= sel_req;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= RSP;
          end
        end
        RSP: begin
          if (done) begin
            if (owner == OWN_LSU) begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_data  <= rsp_d;
              lsu_rsp_err   <= !mem_rsp_valid;
            end else begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_data  <= rsp_d;
              ifu_rsp_err   <= !mem_rsp_valid;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: arbitration table plus hand sequences for stall, timeout and reset.
module tb_mem_arb;
  localparam int W = 32;
  localparam int TMO = 8;
  localparam logic [31:0] KEY = 32'h8000_0413;

  logic clk, rst_n;
  logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [W-1:0] ifu_addr, ifu_rsp_data;
  logic lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid, lsu_rsp_err;
  logic [W-1:0] lsu_addr, lsu_wdata, lsu_rsp_data;
  logic [W/8-1:0] lsu_wmask;
  logic mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [W-1:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [W/8-1:0] mem_wmask;

  mem_arb #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_we(lsu_we), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_rec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_rec_t;

  typedef struct {
    logic        iv, lv, we;
    logic [31:0] ia, la, wd;
    logic [3:0]  wm;
    logic [1:0]  gnt;   // {lsu_ready, ifu_ready}
  } vec_t;

  req_rec_t req_q[$];
  rsp_rec_t ifu_q[$];
  rsp_rec_t lsu_q[$];
  vec_t     tbl[9];

  int n_checks = 0;
  int n_errors = 0;
  logic auto_ready, auto_rsp;
  int got;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Expected memory request and owner response for one accepted transaction.
  task automatic push(input logic own, input logic [31:0] a, input logic we,
                      input logic [31:0] wd, input logic [3:0] wm, input logic err);
    req_rec_t r;
    rsp_rec_t s;
    r.addr  = a;
    r.we    = own ? we : 1'b0;
    r.wdata = own ? wd : 32'h0;
    r.wmask = own ? wm : 4'h0;
    req_q.push_back(r);
    s.err  = err;
    s.data = (err || r.we) ? 32'h0 : (a ^ KEY);
    if (own) lsu_q.push_back(s);
    else     ifu_q.push_back(s);
  endtask

  task automatic monitor();
    rsp_rec_t s;
    if (ifu_rsp_valid) begin
      if (ifu_q.size() == 0) flag("ifu_rsp_unexpected");
      else begin
        s = ifu_q.pop_front();
        chk("ifu_rsp {err,data}", {ifu_rsp_err, ifu_rsp_data}, {s.err, s.data});
      end
    end
    if (lsu_rsp_valid) begin
      if (lsu_q.size() == 0) flag("lsu_rsp_unexpected");
      else begin
        s = lsu_q.pop_front();
        chk("lsu_rsp {err,data}", {lsu_rsp_err, lsu_rsp_data}, {s.err, s.data});
      end
    end
  endtask

  // One clock: check a memory handshake, advance, check responses, drive the memory model.
  task automatic tick();
    logic hs, hs_we;
    logic [31:0] hs_addr;
    req_rec_t r;
    hs      = mem_req_valid && mem_req_ready;
    hs_we   = mem_we;
    hs_addr = mem_addr;
    if (hs) begin
      if (req_q.size() == 0) flag("mem_req_unexpected");
      else begin
        r = req_q.pop_front();
        chk("mem_req {addr,we,wmask}", {mem_addr, mem_we, mem_wmask}, {r.addr, r.we, r.wmask});
        if (r.we) chk("mem_wdata", mem_wdata, r.wdata);
      end
    end
    @(posedge clk);
    #1;
    monitor();
    mem_req_ready = auto_ready;
    mem_rsp_valid = hs && auto_rsp;
    mem_rsp_data  = hs_we ? 32'hFFFF_FFFF : (hs_addr ^ KEY);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (req_q.size() == 0 && ifu_q.size() == 0 && lsu_q.size() == 0) return;
      tick();
    end
    if (req_q.size() != 0 || ifu_q.size() != 0 || lsu_q.size() != 0) begin
      flag("drain_timeout");
      req_q.delete(); ifu_q.delete(); lsu_q.delete();
    end
  endtask

  task automatic drive(input logic iv, input logic lv, input logic [31:0] ia, input logic [31:0] la,
                       input logic we, input logic [31:0] wd, input logic [3:0] wm);
    ifu_req_valid = iv; lsu_req_valid = lv;
    ifu_addr = ia; lsu_addr = la; lsu_we = we; lsu_wdata = wd; lsu_wmask = wm;
  endtask

  function automatic vec_t mk(input logic iv, input logic lv, input logic we, input logic [31:0] ia,
                              input logic [31:0] la, input logic [31:0] wd, input logic [3:0] wm,
                              input logic [1:0] gnt);
    vec_t v;
    v.iv = iv; v.lv = lv; v.we = we; v.ia = ia; v.la = la; v.wd = wd; v.wm = wm; v.gnt = gnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // last_owner is IFU when the table starts (hand sequence 1 precedes it).
    tbl[0] = mk(1, 1, 0, 32'h8000_0008, 32'h8000_0200, 32'h0,         4'h0, 2'b10);
    tbl[1] = mk(1, 1, 0, 32'h8000_000C, 32'h8000_0204, 32'h0,         4'h0, 2'b01);
    tbl[2] = mk(1, 1, 1, 32'h8000_0010, 32'h8000_0104, 32'hCAFE_F00D, 4'hF, 2'b10);
    tbl[3] = mk(0, 1, 0, 32'h0,         32'h8000_0208, 32'h0,         4'h0, 2'b10);
    tbl[4] = mk(1, 1, 0, 32'h8000_0014, 32'h8000_020C, 32'h0,         4'h0, 2'b01);
    tbl[5] = mk(0, 0, 0, 32'h0,         32'h0,         32'h0,         4'h0, 2'b00);
    tbl[6] = mk(1, 0, 0, 32'h8000_0018, 32'h0,         32'h0,         4'h0, 2'b01);
    tbl[7] = mk(1, 1, 1, 32'h8000_001C, 32'h8000_0108, 32'h1234_5678, 4'h5, 2'b10);
    tbl[8] = mk(1, 1, 0, 32'h8000_0020, 32'h8000_0210, 32'h0,         4'h0, 2'b01);

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    auto_ready = 1'b1; auto_rsp = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    @(posedge clk);
    #1;
    chk("reset rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    chk("reset rsp_data/err", {ifu_rsp_data, ifu_rsp_err, lsu_rsp_data, lsu_rsp_err}, 66'h0);
    chk("reset mem fields", {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask}, 70'h0);
    chk("reset ready", {lsu_req_ready, ifu_req_ready}, 2'b00);
    rst_n = 1'b1;
    tick();

    // IFU-only read with zero-wait memory: response in T+3.
    drive(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0);
    #1;
    chk("seq1 ready", {lsu_req_ready, ifu_req_ready}, 2'b01);
    push(0, 32'h8000_0000, 0, 32'h0, 4'h0, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    chk("seq1 mem_req_valid T+1", mem_req_valid, 1'b1);
    tick();
    chk("seq1 no rsp T+2", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    tick();
    chk("seq1 rsp T+3", {lsu_rsp_valid, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data}, {3'b010, 32'h0000_0413});
    drain(10);

    // Arbitration table: readies only in IDLE and only for the round-robin winner.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].iv, tbl[i].lv, tbl[i].ia, tbl[i].la, tbl[i].we, tbl[i].wd, tbl[i].wm);
      #1;
      chk($sformatf("tbl[%0d] grant", i), {lsu_req_ready, ifu_req_ready}, tbl[i].gnt);
      if (tbl[i].gnt == 2'b00) begin
        tick();
        continue;
      end
      if (tbl[i].gnt[1]) push(1, tbl[i].la, tbl[i].we, tbl[i].wd, tbl[i].wm, 0);
      else               push(0, tbl[i].ia, 0, 32'h0, 4'h0, 0);
      tick();
      for (int k = 0; k < 12; k++) begin
        if (ifu_q.size() + lsu_q.size() == 0) break;
        chk($sformatf("tbl[%0d] busy ready", i), {lsu_req_ready, ifu_req_ready}, 2'b00);
        tick();
      end
      drain(4);
    end
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    tick();

    // LSU write with memory stalling 5 cycles: latched fields must hold.
    auto_ready = 1'b0;
    mem_req_ready = 1'b0;
    drive(0, 1, 32'h0, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'b0011);
    #1;
    chk("stall ready", {lsu_req_ready, ifu_req_ready}, 2'b10);
    push(1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'b0011, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall hold[%0d]", i), {mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask},
          {1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011});
      if (i < 4) tick();
    end
    auto_ready = 1'b1;
    mem_req_ready = 1'b1;
    #1;
    drain(10);

    // Lost response: error exactly TMO cycles after entering RSP, then a stray response.
    auto_rsp = 1'b0;
    drive(1, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 4'h0);
    #1;
    chk("tmo ready", {lsu_req_ready, ifu_req_ready}, 2'b01);
    push(0, 32'h8000_0040, 0, 32'h0, 4'h0, 1);
    got = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
      if (ifu_rsp_valid) begin
        got = k;
        break;
      end
    end
    chk("tmo rsp cycle after accept", got, 2 + TMO);
    drain(2);
    tick();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hA5A5_A5A5;
    tick();
    chk("stray dropped 1", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    tick();
    chk("stray dropped 2", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);

    // Reset while in RSP: immediate idle, no response, first tie goes to IFU.
    drive(1, 0, 32'h8000_0080, 32'h0, 0, 32'h0, 4'h0);
    #1;
    push(0, 32'h8000_0080, 0, 32'h0, 4'h0, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    tick();
    ifu_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst mem_req_valid/addr", {mem_req_valid, mem_addr}, 33'h0);
    chk("rst rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    auto_rsp = 1'b1;
    tick();
    chk("rst quiet", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid}, 3'b000);
    drive(1, 1, 32'h8000_0084, 32'h8000_0214, 0, 32'h0, 4'h0);
    #1;
    chk("first tie after reset", {lsu_req_ready, ifu_req_ready}, 2'b01);
    push(0, 32'h8000_0084, 0, 32'h0, 4'h0, 0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 4'h0);
    drain(10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester memory arbiter for the multi-cycle core. Shares one downstream memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). Grants round-robin, holds the request through a valid/ready handshake and routes each response back to its owner. A response watchdog prevents a lost response from hanging the core.

## Interface
Parameters:
- WIDTH, 32, address/data width
- TIMEOUT, 255, maximum cycles in RSP before an error response is returned; must be at least 2

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  WIDTH  IFU read address
- ifu_rsp_valid  out  1  one-cycle pulse: IFU response
- ifu_rsp_data  out  WIDTH  IFU read data
- ifu_rsp_err  out  1  IFU response is a timeout error
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  WIDTH  LSU address
- lsu_we  in  1  1 = write, 0 = read
- lsu_wdata  in  WIDTH  write data
- lsu_wmask  in  WIDTH/8  byte write strobes
- lsu_rsp_valid  out  1  one-cycle pulse: LSU response (reads and writes)
- lsu_rsp_data  out  WIDTH  LSU read data; 0 for writes
- lsu_rsp_err  out  1  LSU response is a timeout error
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_addr, mem_we, mem_wdata, mem_wmask  out  WIDTH/1/WIDTH/WIDTH/8  latched request fields
- mem_rsp_valid  in  1  downstream response
- mem_rsp_data  in  WIDTH  downstream read data

## Operation
- FSM states:
  - IDLE: accept one request.
  - REQ: drive mem_req_valid and wait for mem_req_ready.
  - RSP: wait for mem_rsp_valid or timeout.
- Arbitration (IDLE only):
  - Only one requester valid: that one wins.
  - Both valid: the one not granted last wins (tracked by last_owner).
  - *_req_ready is combinational, asserted only in IDLE and only for the winner.
- Accept (IDLE, valid & ready):
  - Latch owner, addr, we, wdata and wmask into registers; go to REQ; update last_owner.
  - IFU requests latch we=0 and wmask=0.
- REQ:
  - mem_req_valid=1; mem_* outputs driven from the latched registers and held stable.
  - On mem_req_ready, go to RSP and clear the watchdog counter.
- RSP:
  - On mem_rsp_valid, register data into the owner's rsp_data, pulse the owner's rsp_valid next cycle with err=0, and go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1, pulse the owner's rsp_valid with err=1 and data=0, and go to IDLE.
- mem_rsp_valid in IDLE or REQ (stray or late response) is ignored and not forwarded.
- Non-owner rsp_valid is never asserted; rsp_data holds its last value.

## Timing
- Reset values:
  - state=IDLE, last_owner=LSU (IFU wins first tie), counter=0.
  - All rsp_valid=0, rsp_data=0, rsp_err=0.
  - mem_req_valid=0; latched fields=0.
- Zero-wait-state memory:
  - Accept at cycle T, mem_req_valid at T+1.
  - mem_req_ready at T+1 → RSP at T+2.
  - mem_rsp_valid at T+2 → owner rsp_valid at T+3.
  - The next request can be accepted in the same cycle as T+3 (the FSM is back in IDLE).
- One outstanding transaction only. Requesters must hold valid and payload until ready.
- Timeout: rsp_valid with err=1 exactly TIMEOUT cycles after entering RSP.
- Asynchronous reset mid-transaction: immediately returns to IDLE. No response is emitted and mem_req_valid drops.

## Structure
- Package mem_arb_pkg:
  - State encoding (IDLE=2'd0, REQ=2'd1, RSP=2'd2).
  - Owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1).
  - Default TIMEOUT constant.
- Sub-module rr_arb2: combinational two-way round-robin picker. Inputs: two valids and last_owner. Outputs: grant one-hot.
- mem_arb holds the FSM, request latch, watchdog counter and response routing.

## Test plan
- IFU-only read at 0x8000_0000, memory ready and responding immediately with 0x0000_0413 → ifu_rsp_valid at T+3, data 0x0000_0413, err=0, lsu_rsp_valid stays 0.
- Both requesting every cycle after reset → grants alternate IFU, LSU, IFU, LSU; each ready pulse lands only in IDLE.
- LSU write addr 0x8000_0100, wdata 0xDEADBEEF, wmask 4'b0011, mem_req_ready held low 5 cycles → mem_* fields stable all 5 cycles; lsu_rsp_valid follows the response with data 0.
- No mem_rsp_valid with TIMEOUT=8 → owner rsp_valid with err=1 and data 0 exactly 8 cycles after entering RSP. A mem_rsp_valid arriving 2 cycles later is dropped.
- rst_n asserted while in RSP → same-cycle return to IDLE, mem_req_valid=0, no rsp_valid. The first tie after release grants IFU.
